instr_rom_loader: RTL
=====================

Name: instr_rom_loader

Overview:
- Instruction-side responder for the 8-bit datapath CPU: drives `instruction` from the CPU's `readingAddress`.
- Stores a program in a DEPTH-entry byte memory, loaded at runtime over a valid/ready byte stream from switches, UART or a test bench.
- Holds the CPU via `cpu_hold` while no program is running.
- Entries never written since the last load read back as a self-loop halt word, so a short program parks the CPU instead of executing garbage.

Parameters:
- DEPTH, 32, number of program bytes stored; legal range 1..256.
- HALT_WORD, 8'hC3, value returned for unwritten or out-of-range addresses (jump opcode 2'b11, offset 2'b11: pc holds).

Ports:
- CLK  input  1  system clock (50 MHz)
- reset  input  1  asynchronous, active-high reset
- load_start  input  1  single-cycle pulse: begin a new program load
- run_start  input  1  single-cycle pulse: release CPU with current contents
- load_data  input  8  program byte
- load_valid  input  1  load_data valid
- load_last  input  1  qualifies the final byte of the program
- load_ready  output  1  loader accepts a byte this cycle
- load_done  output  1  one-cycle pulse when a load completes
- load_count  output  8  bytes written in the current/last load
- readingAddress  input  8  instruction address from CPU
- instruction  output  8  registered instruction byte
- cpu_hold  output  1  high when state is not RUN
- checksum  output  8  running mod-256 sum of loaded bytes (see Optional Feature)

Behaviour:
- Reset values:
  - state IDLE; write pointer 0
  - all per-entry valid bits cleared; memory data not cleared
  - instruction = HALT_WORD, load_ready = 0, load_done = 0, load_count = 0, checksum = 0, cpu_hold = 1
- States:
  - IDLE: load_start -> LOAD; else run_start -> RUN. Load wins if both are asserted in the same cycle.
  - LOAD: load_ready = 1.
    - A beat is load_valid & load_ready: write mem[ptr], set valid[ptr], ptr++, load_count++.
    - Beat with load_last, or beat at ptr == DEPTH-1 -> RUN next cycle, with load_done pulsed in that cycle.
    - run_start is ignored.
  - RUN: cpu_hold = 0, load_ready = 0. load_start -> LOAD.
- Entry to LOAD (from any state, including load_start while already in LOAD):
  - ptr = 0, load_count = 0, checksum = 0, all valid bits cleared.
  - A beat presented in the same cycle as that load_start is dropped.
- Read path, 1-cycle latency: on each CLK edge, instruction <= mem[readingAddress] when all of the following hold; else HALT_WORD:
  - state == RUN
  - readingAddress < DEPTH
  - valid[readingAddress]
- Address wrap: readingAddress >= DEPTH (including pc wrap to 255 from pc-1 at 0) returns HALT_WORD.
- Reset mid-load:
  - Returns to IDLE with all valid bits cleared.
  - Partial program is invisible; run_start then yields only HALT_WORD.
- load_count saturates at DEPTH and holds after load_done until the next load_start.
- No write occurs when ptr == DEPTH (unreachable by construction; assertion required).

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- Defined: checksum accumulates the mod-256 sum of every accepted byte and holds its value in RUN and IDLE.
- Undefined: checksum is tied to 8'h00 and no adder is synthesized.
- The port exists in both builds.

Decomposition:
- Shared package instr_loader_pkg holds:
  - state enum (IDLE, LOAD, RUN)
  - HALT_WORD default
  - CPU opcode constants OP_ADD = 2'b00, OP_LOAD = 2'b01, OP_STORE = 2'b10, OP_JUMP = 2'b11, shared with the CPU
- Sub-module instr_mem_array: DEPTH x 8 storage with one synchronous write port and one synchronous read port, plus the valid-bit vector with a bulk-clear input.
- FSM and counters live in the top.

Test Plan:
- Reset, then run_start, then readingAddress = 0..3 -> instruction = 8'hC3 every cycle; cpu_hold falls one cycle after run_start.
- load_start, then beats 8'h06, 8'h1B, 8'hC3 (last on third) -> load_done pulses once, load_count = 3, checksum = 8'hE4 (CHECKSUM_EN), RUN; addr 1 -> 8'h1B one cycle later; addr 5 -> 8'hC3.
- Stream 32 bytes 8'h00..8'h1F without load_last -> RUN after 32nd beat, load_count = 32; addr 31 -> 8'h1F; addr 255 -> 8'hC3.
- load_valid held with load_start re-pulsed after 2 beats -> load_count restarts at 0, first post-restart beat lands at addr 0, and the earlier bytes at addresses 0-1 are replaced.
- Async reset asserted after 2 of 4 beats, then run_start -> all reads 8'hC3, load_count = 0.
- load_start and run_start asserted in the same cycle in IDLE -> state LOAD, cpu_hold stays 1.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared state, opcode and halt-word definitions for the
// instruction loader and the 8-bit CPU it feeds.
package instr_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   // jump opcode with offset 3: pc holds, CPU parks
   localparam logic [7:0] HALT_WORD_DEF = 8'hC3;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;
   localparam logic [1:0] OP_JUMP  = 2'b11;

   function automatic int unsigned idx_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x 8 program store: one sync write port, one registered
// read port, per-entry valid bits with bulk clear.
module instr_mem_array
   import instr_loader_pkg::*;
#(
   parameter int unsigned DEPTH     = 32,
   parameter logic [7:0]  HALT_WORD = HALT_WORD_DEF,
   parameter int unsigned AW        = idx_w(DEPTH)
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          i_clr,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic          i_ren,
   input  logic [AW-1:0] i_raddr,
   output logic [7:0]    o_rdata
);

   logic [7:0]       r_mem [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [7:0]       r_rdata;
   logic             w_hit;

   assign w_hit   = i_ren && r_valid[i_raddr];
   assign o_rdata = r_rdata;

   always_ff @(posedge CLK) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // data is never cleared; the valid bits hide stale entries
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_valid <= '0;
      end else if (i_clr) begin
         r_valid <= '0;
      end else if (i_we) begin
         r_valid[i_waddr] <= 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_rdata <= HALT_WORD;
      end else begin
         r_rdata <= w_hit ? r_mem[i_raddr] : HALT_WORD;
      end
   end

endmodule

// File: rtl/instr_rom_loader.sv
// Runtime-loadable instruction ROM with CPU hold control.
// Define INSTR_LOADER_CHECKSUM_EN to enable the checksum adder.
module instr_rom_loader
   import instr_loader_pkg::*;
#(
   parameter int unsigned DEPTH     = 32,
   parameter logic [7:0]  HALT_WORD = HALT_WORD_DEF
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       load_start,
   input  logic       run_start,
   input  logic [7:0] load_data,
   input  logic       load_valid,
   input  logic       load_last,
   output logic       load_ready,
   output logic       load_done,
   output logic [7:0] load_count,
   input  logic [7:0] readingAddress,
   output logic [7:0] instruction,
   output logic       cpu_hold,
   output logic [7:0] checksum
);

   localparam int unsigned AW   = idx_w(DEPTH);
   localparam logic [8:0]  LIM  = 9'(DEPTH);
   localparam logic [8:0]  LAST = 9'(DEPTH - 1);

   state_t     r_state;
   logic [8:0] r_ptr;
   logic       r_ready;
   logic       r_done;
   logic       r_hold;

   logic       w_we;
   logic       w_end;
   logic       w_ren;

   // a beat coinciding with load_start is dropped
   assign w_we  = (r_state == ST_LOAD) && load_valid && !load_start;
   assign w_end = w_we && (load_last || r_ptr == LAST);
   assign w_ren = (r_state == ST_RUN) && ({1'b0, readingAddress} < LIM);

   assign load_ready = r_ready;
   assign load_done  = r_done;
   assign cpu_hold   = r_hold;
   assign load_count = r_ptr[8] ? 8'hFF : r_ptr[7:0];

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_ready <= 1'b0;
         r_done  <= 1'b0;
         r_hold  <= 1'b1;
      end else begin
         r_done <= 1'b0;
         if (load_start) begin
            r_state <= ST_LOAD;
            r_ptr   <= '0;
            r_ready <= 1'b1;
            r_hold  <= 1'b1;
         end else begin
            unique case (r_state)
               ST_IDLE: begin
                  if (run_start) begin
                     r_state <= ST_RUN;
                     r_hold  <= 1'b0;
                  end
               end
               ST_LOAD: begin
                  if (w_we) begin
                     r_ptr <= r_ptr + 9'd1;
                  end
                  if (w_end) begin
                     r_state <= ST_RUN;
                     r_ready <= 1'b0;
                     r_hold  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
               ST_RUN: begin
                  r_hold <= 1'b0;
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b0;
                  r_hold  <= 1'b1;
               end
            endcase
         end
      end
   end

`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [7:0] r_sum;

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_sum <= '0;
      end else if (load_start) begin
         r_sum <= '0;
      end else if (w_we) begin
         r_sum <= r_sum + load_data;
      end
   end

   assign checksum = r_sum;
`else
   assign checksum = 8'h00;
`endif

   a_no_overrun: assert property (
      @(posedge CLK) disable iff (reset) !(w_we && r_ptr >= LIM)
   );

   instr_mem_array #(
      .DEPTH     (DEPTH),
      .HALT_WORD (HALT_WORD),
      .AW        (AW)
   ) u_mem (
      .CLK     (CLK),
      .reset   (reset),
      .i_clr   (load_start),
      .i_we    (w_we),
      .i_waddr (r_ptr[AW-1:0]),
      .i_wdata (load_data),
      .i_ren   (w_ren),
      .i_raddr (readingAddress[AW-1:0]),
      .o_rdata (instruction)
   );

endmodule
